// File: rtl/instr_fetch_unit.sv
// Multicycle MIPS instruction fetch stage.
// Fetches one 32-bit word as four byte reads (low byte first) over a req/ack
// handshake with a variable-latency 8-bit memory, then presents the committed
// word together with its op/funct fields.
// Optional feature: define IFU_TIMEOUT_EN to enable the per-byte ack timeout
// (TIMEOUT_CYC cycles) and the sticky err_o flag. Without it err_o is tied 0
// and a fetch waits for memory indefinitely.

module instr_fetch_unit #(
    parameter int unsigned ADDR_W      = 32
`ifdef IFU_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_rdata_i,
    output logic [31:0]       instr_o,
    output logic [5:0]        op_o,
    output logic [5:0]        funct_o,
    output logic              instr_valid_o,
    output logic              busy_o,
    output logic [1:0]        byte_idx_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_t;

    state_t            r_state, w_state_d;
    logic [ADDR_W-1:0] r_base, w_base_d;
    logic [1:0]        r_byte_idx, w_byte_idx_d;
    logic [23:0]       r_buf, w_buf_d;
    logic [31:0]       r_instr, w_instr_d;
    logic              r_valid, w_valid_d;
    logic [ADDR_W-1:0] w_pc_aligned;

`ifdef IFU_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic              r_err, w_err_d;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_d;
`endif

    // Word-align the fetch address by masking the two byte-offset bits.
    assign w_pc_aligned = pc_i & ~ADDR_W'(3);

    // State and datapath registers; reset aborts any fetch without committing.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= StIdle;
            r_base     <= '0;
            r_byte_idx <= '0;
            r_buf      <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_base     <= w_base_d;
            r_byte_idx <= w_byte_idx_d;
            r_buf      <= w_buf_d;
            r_instr    <= w_instr_d;
            r_valid    <= w_valid_d;
`ifdef IFU_TIMEOUT_EN
            r_err      <= w_err_d;
            r_wait_cnt <= w_wait_cnt_d;
`endif
        end
    end

    // Next-state logic: accept start, assemble bytes on ack, commit on the last byte.
    always_comb begin
        w_state_d    = r_state;
        w_base_d     = r_base;
        w_byte_idx_d = r_byte_idx;
        w_buf_d      = r_buf;
        w_instr_d    = r_instr;
        w_valid_d    = r_valid;
`ifdef IFU_TIMEOUT_EN
        w_err_d      = r_err;
        w_wait_cnt_d = r_wait_cnt;
`endif

        unique case (r_state)
            StIdle, StDone: begin
                if (start_i) begin
                    w_state_d    = StReq;
                    w_base_d     = w_pc_aligned;
                    w_byte_idx_d = '0;
                    w_valid_d    = 1'b0;
`ifdef IFU_TIMEOUT_EN
                    w_err_d      = 1'b0;
                    w_wait_cnt_d = '0;
`endif
                end
            end

            StReq: begin
                if (mem_ack_i) begin
`ifdef IFU_TIMEOUT_EN
                    w_wait_cnt_d = '0;
`endif
                    unique case (r_byte_idx)
                        2'd0: w_buf_d[7:0]   = mem_rdata_i;
                        2'd1: w_buf_d[15:8]  = mem_rdata_i;
                        2'd2: w_buf_d[23:16] = mem_rdata_i;
                        2'd3: begin
                            // Last byte goes straight into the committed word.
                            w_instr_d = {mem_rdata_i, r_buf};
                            w_valid_d = 1'b1;
                            w_state_d = StDone;
                        end
                        default: w_state_d = StIdle;
                    endcase
                    if (r_byte_idx != 2'd3) begin
                        w_byte_idx_d = r_byte_idx + 2'd1;
                    end
                end
`ifdef IFU_TIMEOUT_EN
                else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
                    // Give up: flag the error, keep the previously committed word.
                    w_state_d = StIdle;
                    w_err_d   = 1'b1;
                    w_valid_d = 1'b0;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + WAIT_W'(1);
                end
`endif
            end

            default: w_state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state so reset removes the request immediately.
    always_comb begin
        mem_req_o     = (r_state == StReq);
        busy_o        = (r_state == StReq);
        mem_addr_o    = mem_req_o ? (r_base + ADDR_W'(r_byte_idx)) : '0;
        byte_idx_o    = r_byte_idx;
        instr_o       = r_instr;
        op_o          = r_instr[31:26];
        funct_o       = r_instr[5:0];
        instr_valid_o = r_valid;
`ifdef IFU_TIMEOUT_EN
        err_o         = r_err;
`else
        err_o         = 1'b0;
`endif
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a byte-array memory model answers
// requests with configurable wait states, expected words and byte addresses are
// queued at issue time, and monitors compare them as the DUT presents them.

module tb_instr_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_rdata_i = '0;
    logic [31:0] instr_o;
    logic [5:0]  op_o;
    logic [5:0]  funct_o;
    logic        instr_valid_o;
    logic        busy_o;
    logic [1:0]  byte_idx_o;
    logic        err_o;

    instr_fetch_unit dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .instr_o      (instr_o),
        .op_o         (op_o),
        .funct_o      (funct_o),
        .instr_valid_o(instr_valid_o),
        .busy_o       (busy_o),
        .byte_idx_o   (byte_idx_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-addressed memory; unwritten locations get a random byte on first touch.
    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];

    // Memory responder: 0 = no wait, 1 = random 0..3 waits, 2 = 3 waits on byte 2, 3 = never ack.
    int mode = 0;
    bit stray_ack = 1'b0;
    int wait_left = 0;
    bit new_req = 1'b1;

    function automatic int pick_wait(input logic [1:0] idx);
        case (mode)
            1:       return int'($urandom_range(0, 3));
            2:       return (idx == 2'd2) ? 3 : 0;
            default: return 0;
        endcase
    endfunction

    // Decide ack/rdata a little after each rising edge, once DUT outputs settle.
    always @(posedge clk_i) begin
        #2;
        if (!rst_n_i) begin
            mem_ack_i = 1'b0;
            new_req = 1'b1;
        end else if (mem_req_o) begin
            if (new_req) begin
                wait_left = pick_wait(mem_addr_o[1:0]);
                new_req = 1'b0;
            end
            if (mode != 3 && wait_left == 0) begin
                mem_ack_i = 1'b1;
                mem_rdata_i = mem_rd(mem_addr_o);
                new_req = 1'b1;
            end else begin
                mem_ack_i = 1'b0;
                mem_rdata_i = 8'($urandom);
                if (wait_left > 0) wait_left--;
            end
        end else begin
            mem_ack_i = stray_ack;
            mem_rdata_i = 8'($urandom);
            new_req = 1'b1;
        end
    end

    // Monitor: byte addresses against the address queue, commits against the word queue.
    logic [31:0] model_instr = '0;
    bit prev_valid = 1'b0;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            model_instr = '0;
            prev_valid = 1'b0;
        end else begin
            if (mem_req_o) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_req", mem_addr_o, 32'hDEAD_BEEF);
                end else begin
                    check("mem_addr", mem_addr_o, addr_q[0]);
                    check("byte_idx", {30'd0, byte_idx_o}, {30'd0, addr_q[0][1:0]});
                    if (mem_ack_i) void'(addr_q.pop_front());
                end
            end
            if (instr_valid_o && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", instr_o, 32'hDEAD_BEEF);
                end else begin
                    model_instr = exp_q.pop_front();
                    check("instr", instr_o, model_instr);
                    check("op", {26'd0, op_o}, {26'd0, model_instr[31:26]});
                    check("funct", {26'd0, funct_o}, {26'd0, model_instr[5:0]});
                end
            end else begin
                check("instr_hold", instr_o, model_instr);
            end
`ifndef IFU_TIMEOUT_EN
            check("err_tied", {31'd0, err_o}, 32'd0);
`endif
            prev_valid = instr_valid_o;
        end
    end

    // Queue expectations for a fetch of pc, then pulse start for one cycle.
    task automatic issue(input logic [31:0] pc);
        logic [31:0] b;
        logic [31:0] w;
        b = pc & 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = mem_rd(b + 32'(k));
            addr_q.push_back(b + 32'(k));
        end
        exp_q.push_back(w);
        @(posedge clk_i);
        #1;
        pc_i = pc;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        pc_i = $urandom;
    endtask

    // Called in cycle 1 after issue; returns the cycle valid was seen and the req cycle count.
    task automatic wait_valid(input int limit, output int cyc, output int reqs);
        cyc = 1;
        reqs = 0;
        while (!instr_valid_o && cyc < limit) begin
            if (mem_req_o) reqs++;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check("valid_seen", {31'd0, instr_valid_o}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int reqs;

        #2 rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_idx", {30'd0, byte_idx_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_opfn", {20'd0, op_o, funct_o}, 32'd0);
        rst_n_i = 1'b1;

        // Zero-wait fetch of a known word.
        mem[32'h100] = 8'h8C;
        mem[32'h101] = 8'h10;
        mem[32'h102] = 8'h22;
        mem[32'h103] = 8'h00;
        mode = 0;
        issue(32'h100);
        wait_valid(20, cyc, reqs);
        check("zw_latency", cyc, 5);
        check("zw_req_cycles", reqs, 4);
        check("zw_instr", instr_o, 32'h0022_108C);
        check("zw_op", {26'd0, op_o}, 32'h00);
        check("zw_funct", {26'd0, funct_o}, 32'h0C);
        check("zw_req_done", {31'd0, mem_req_o}, 32'd0);
        check("zw_busy_done", {31'd0, busy_o}, 32'd0);

        // Three wait states on byte 2.
        mode = 2;
        issue(32'h200);
        wait_valid(30, cyc, reqs);
        check("ws_latency", cyc, 8);
        check("ws_req_cycles", reqs, 7);

        // Alignment and wrap at the top of memory.
        mode = 0;
        issue(32'hFFFF_FFFF);
        wait_valid(20, cyc, reqs);
        check("wrap_latency", cyc, 5);
        issue(32'h0000_0006);
        wait_valid(20, cyc, reqs);
        check("align_latency", cyc, 5);

        // start_i during REQ is ignored; stray acks in DONE change nothing.
        mode = 1;
        issue(32'h0000_0400);
        start_i = 1'b1;
        pc_i = 32'h0000_0800;
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        start_i = 1'b0;
        wait_valid(60, cyc, reqs);
        stray_ack = 1'b1;
        repeat (4) begin
            @(posedge clk_i);
            #1;
            check("stray_no_req", {31'd0, mem_req_o}, 32'd0);
            check("stray_valid", {31'd0, instr_valid_o}, 32'd1);
        end
        stray_ack = 1'b0;

        // Asynchronous reset in the middle of a fetch.
        mode = 3;
        issue(32'h0000_0500);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        check("arst_req", {31'd0, mem_req_o}, 32'd0);
        check("arst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("arst_instr", instr_o, 32'd0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        mode = 0;
        issue(32'h0000_0600);
        wait_valid(20, cyc, reqs);
        check("post_rst_latency", cyc, 5);

`ifdef IFU_TIMEOUT_EN
        // Ack never arrives: fetch abandons after 16 REQ cycles.
        mode = 3;
        issue(32'h0000_0700);
        cyc = 1;
        reqs = 0;
        while (mem_req_o && cyc < 40) begin
            reqs++;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check("to_req_cycles", reqs, 16);
        check("to_req", {31'd0, mem_req_o}, 32'd0);
        check("to_err", {31'd0, err_o}, 32'd1);
        check("to_busy", {31'd0, busy_o}, 32'd0);
        check("to_valid", {31'd0, instr_valid_o}, 32'd0);
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(posedge clk_i);
        #1;
        check("to_err_sticky", {31'd0, err_o}, 32'd1);
        mode = 0;
        issue(32'h0000_0710);
        check("to_err_clear", {31'd0, err_o}, 32'd0);
        wait_valid(20, cyc, reqs);
`endif

        // Randomized fetches with random wait states and stray starts.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] pc;
            mode = int'($urandom_range(0, 2));
            pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
            issue(pc);
            if ($urandom_range(0, 1) == 1) begin
                start_i = 1'b1;
                @(posedge clk_i);
                #1;
                start_i = 1'b0;
            end
            wait_valid(60, cyc, reqs);
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
        end

        repeat (4) @(posedge clk_i);
        #1;
        check("drain_words", exp_q.size(), 0);
        check("drain_addrs", addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
